// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Function : Iterative double-dabble binary-to-BCD converter, one bit per
//            clock, start/busy/done handshake. Optional macro
//            BIN_TO_BCD_BLANK_EN adds a leading-zero blank mask output.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN_TO_BCD_BLANK_EN
   output logic [DIGITS-1:0]     blank,
`endif
   output logic                  overflow
);

   localparam int C_SW    = 4 * DIGITS;
   localparam int C_CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_last;

   logic [BIN_W-1:0]    r_shift;
   logic [C_SW-1:0]     r_scratch;
   logic                r_ovf;
   logic [C_CNT_W-1:0]  r_cnt;

   logic [C_SW-1:0]     w_adj;
   logic [C_SW-1:0]     w_scr_nxt;
   logic [BIN_W-1:0]    w_shift_nxt;
   logic                w_ovf_nxt;

   // Add-3 correction is applied to every digit before the shift.
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                               r_scratch[4*i +: 4] + 4'd3 :
                               r_scratch[4*i +: 4];
   end

   assign w_scr_nxt   = {w_adj[C_SW-2:0], r_shift[BIN_W-1]};
   assign w_shift_nxt = r_shift << 1;
   assign w_ovf_nxt   = r_ovf | w_adj[C_SW-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == C_CNT_W'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef BIN_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] w_blank;

   // Digit i is blanked when it and every higher digit are zero; the ones
   // digit is never blanked so a zero value still shows one "0".
   for (genvar i = 0; i < DIGITS; i++) begin : g_blank
      if (i == 0) begin : g_lsd
         assign w_blank[i] = 1'b0;
      end else begin : g_upper
         assign w_blank[i] = ~|w_scr_nxt[C_SW-1:4*i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blank <= '0;
      end else if (w_last) begin
         blank <= w_blank;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd_out   <= '0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_accept) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= C_CNT_W'(BIN_W);
            busy      <= 1'b1;
         end else if (r_state == S_SHIFT) begin
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scr_nxt;
            r_ovf     <= w_ovf_nxt;
            r_cnt     <= r_cnt - C_CNT_W'(1);
            if (w_last) begin
               bcd_out  <= w_scr_nxt;
               overflow <= w_ovf_nxt;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Function : Directed self-checking bench for bin_to_bcd_seq (DIGITS=3 and
//            DIGITS=2 instances sharing stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  bin_in;
   logic        busy, done, overflow;
   logic [11:0] bcd_out;
   logic        busy2, done2, overflow2;
   logic [7:0]  bcd_out2;
`ifdef BIN_TO_BCD_BLANK_EN
   logic [2:0]  blank;
   logic [1:0]  blank2;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out),
`ifdef BIN_TO_BCD_BLANK_EN
      .blank(blank),
`endif
      .overflow(overflow)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy2), .done(done2), .bcd_out(bcd_out2),
`ifdef BIN_TO_BCD_BLANK_EN
      .blank(blank2),
`endif
      .overflow(overflow2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller sits on a negedge; returns edges from accept to done and busy cycles.
   task automatic do_conv(input logic [7:0] v, output int lat, output int bsy);
      bin_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bin_in = ~v;
      lat = 0;
      bsy = 0;
      while (!done && lat < 40) begin
         if (busy) bsy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_done(input int n, output int nd);
      nd = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done || done2) nd++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bsy, nd, t1, t2;
      reset  = 1'b1;
      start  = 1'b0;
      bin_in = 8'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bcd", bcd_out, 12'h000);
      chk("rst_ovf", overflow, 0);
      chk("rst_bcd2", bcd_out2, 8'h00);
      chk("rst_ovf2", overflow2, 0);
`ifdef BIN_TO_BCD_BLANK_EN
      chk("rst_blank", blank, 3'b000);
`endif

      // Zero input: latency and busy duration
      do_conv(8'd0, lat, bsy);
      chk("zero_lat", lat, 8);
      chk("zero_busy_cycles", bsy, 8);
      chk("zero_bcd", bcd_out, 12'h000);
      chk("zero_ovf", overflow, 0);
      chk("zero_busy_at_done", busy, 0);
`ifdef BIN_TO_BCD_BLANK_EN
      chk("zero_blank", blank, 3'b110);
`endif
      @(negedge clk);
      chk("zero_done_pulse", done, 0);

      // Back-to-back: each start issued in the previous done cycle
      do_conv(8'd255, lat, bsy);
      t1 = cyc;
      chk("b2b255_bcd", bcd_out, 12'h255);
      chk("b2b255_ovf", overflow, 0);
      chk("d2_255_bcd", bcd_out2, 8'h55);
      chk("d2_255_ovf", overflow2, 1);
      do_conv(8'd99, lat, bsy);
      t2 = cyc;
      chk("b2b99_bcd", bcd_out, 12'h099);
      chk("b2b_gap", t2 - t1, 9);
      chk("d2_99_bcd", bcd_out2, 8'h99);
      chk("d2_99_ovf", overflow2, 0);
      t1 = t2;
      do_conv(8'd10, lat, bsy);
      t2 = cyc;
      chk("b2b10_bcd", bcd_out, 12'h010);
      chk("b2b_gap2", t2 - t1, 9);
      @(negedge clk);

      // Start during busy must be ignored
      bin_in = 8'd128;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (2) @(negedge clk);
      chk("ign_bcd_hold", bcd_out, 12'h010);
      bin_in = 8'd7;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      lat = 3;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("ign_lat", lat, 8);
      chk("ign_bcd", bcd_out, 12'h128);
      chk("d2_128_bcd", bcd_out2, 8'h28);
      chk("d2_128_ovf", overflow2, 1);
      count_done(12, nd);
      chk("ign_no_extra_done", nd, 0);

      // Reset mid-conversion aborts
      bin_in = 8'd200;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_bcd", bcd_out, 12'h000);
      chk("abort_ovf2", overflow2, 0);
      count_done(12, nd);
      chk("abort_no_done", nd, 0);
      do_conv(8'd42, lat, bsy);
      chk("after_abort_bcd", bcd_out, 12'h042);
      chk("after_abort_lat", lat, 8);
      chk("d2_42_bcd", bcd_out2, 8'h42);
`ifdef BIN_TO_BCD_BLANK_EN
      chk("blank_42", blank, 3'b100);
      do_conv(8'd7, lat, bsy);
      chk("blank_7", blank, 3'b110);
      chk("bcd_7", bcd_out, 12'h007);
      do_conv(8'd105, lat, bsy);
      chk("blank_105", blank, 3'b000);
      chk("bcd_105", bcd_out, 12'h105);
      chk("d2_105_blank", blank2, 2'b10);
`endif
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
